// File: rtl/vga_bridge_pkg.sv
// Shared definitions for the VGA command bridge: word layout, opcodes, FSM states.
// The CLEAR state exists only when VGA_BRIDGE_CLEAR_EN is defined.
package vga_bridge_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned FB_AW    = 17;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 8;
  localparam int unsigned RSVD_W   = 2;
  localparam int unsigned COL_W    = 8;

  localparam int unsigned OP_LSB   = 28;
  localparam int unsigned X_LSB    = 18;
  localparam int unsigned Y_LSB    = 10;
  localparam int unsigned RSVD_LSB = 8;
  localparam int unsigned COL_LSB  = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_PIXEL = 4'd1,
    OP_CLEAR = 4'd2
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef VGA_BRIDGE_CLEAR_EN
    ST_PIXEL = 2'd1,
    ST_CLEAR = 2'd2
`else
    ST_PIXEL = 2'd1
`endif
  } state_e;

endpackage

// File: rtl/vga_cmd_fifo.sv
// Command FIFO for the VGA bridge; push while full succeeds only with a same-cycle pop.
// Independent of VGA_BRIDGE_CLEAR_EN.
module vga_cmd_fifo
  import vga_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [WORD_W-1:0]         i_din,
  input  logic                      i_pop,
  output logic [WORD_W-1:0]         o_dout,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_cnt_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_cnt;
  logic              r_full;
  logic              r_empty;
  logic              w_pop_ok;
  logic              w_push_ok;
  logic [CW-1:0]     w_cnt_nxt;

  assign w_pop_ok    = i_pop && !r_empty;
  assign w_push_ok   = i_push && (!r_full || w_pop_ok);
  assign w_cnt_nxt   = r_cnt + CW'(w_push_ok) - CW'(w_pop_ok);
  assign o_cnt_nxt_c = w_cnt_nxt;
  assign o_dout      = r_mem[r_rd_ptr];
  assign o_full      = r_full;
  assign o_empty     = r_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/vga_cmd_bridge.sv
// Turns register-15 command words into framebuffer pixel writes (PIXEL, optional CLEAR).
// Define VGA_BRIDGE_CLEAR_EN to build the CLEAR opcode; otherwise opcode 2 is a NOP.
module vga_cmd_bridge
  import vga_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_RES      = 320,
  parameter int unsigned V_RES      = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_wr,
  input  logic [WORD_W-1:0] vga_word,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [COL_W-1:0]  fb_data,
  input  logic              fb_ready,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(H_RES * V_RES - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WORD_W-1:0] r_cmd;
  logic              r_cmd_vld;
  logic              w_cmd_vld_nxt;
  logic              r_fb_we;
  logic              w_fb_we_nxt;
  logic [FB_AW-1:0]  r_fb_addr;
  logic [FB_AW-1:0]  w_fb_addr_nxt;
  logic [COL_W-1:0]  r_fb_data;
  logic [COL_W-1:0]  w_fb_data_nxt;
  logic              r_busy;
  logic              r_ovf;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_dout;
  logic [CW-1:0]     w_cnt_nxt;

  logic [OP_W-1:0]   w_op;
  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic [COL_W-1:0]  w_col;
  logic              w_in_range;
  logic [FB_AW-1:0]  w_pix_addr;
  logic              w_unused;

  vga_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (vga_wr),
    .i_din       (vga_word),
    .i_pop       (w_pop),
    .o_dout      (w_dout),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_cnt_nxt_c (w_cnt_nxt)
  );

  assign w_op       = r_cmd[OP_LSB +: OP_W];
  assign w_x        = r_cmd[X_LSB +: X_W];
  assign w_y        = r_cmd[Y_LSB +: Y_W];
  assign w_col      = r_cmd[COL_LSB +: COL_W];
  assign w_unused   = ^r_cmd[RSVD_LSB +: RSVD_W];
  assign w_in_range = (32'(w_x) < H_RES) && (32'(w_y) < V_RES);
  assign w_pix_addr = FB_AW'(w_y) * FB_AW'(H_RES) + FB_AW'(w_x);

  assign fb_we   = r_fb_we;
  assign fb_addr = r_fb_addr;
  assign fb_data = r_fb_data;
  assign busy    = r_busy;
  assign ovf     = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // IDLE alternates pop-and-latch with decode, giving one command per three cycles.
  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_vld_nxt = r_cmd_vld;
    w_fb_we_nxt   = r_fb_we;
    w_fb_addr_nxt = r_fb_addr;
    w_fb_data_nxt = r_fb_data;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_cmd_vld) begin
          w_cmd_vld_nxt = 1'b0;
          if (w_op == OP_PIXEL && w_in_range) begin
            w_state_nxt   = ST_PIXEL;
            w_fb_we_nxt   = 1'b1;
            w_fb_addr_nxt = w_pix_addr;
            w_fb_data_nxt = w_col;
          end
`ifdef VGA_BRIDGE_CLEAR_EN
          else if (w_op == OP_CLEAR) begin
            w_state_nxt   = ST_CLEAR;
            w_fb_we_nxt   = 1'b1;
            w_fb_addr_nxt = '0;
            w_fb_data_nxt = w_col;
          end
`endif
        end else if (!w_empty) begin
          w_pop         = 1'b1;
          w_cmd_vld_nxt = 1'b1;
        end
      end
      ST_PIXEL: begin
        if (fb_ready) begin
          w_state_nxt = ST_IDLE;
          w_fb_we_nxt = 1'b0;
        end
      end
`ifdef VGA_BRIDGE_CLEAR_EN
      ST_CLEAR: begin
        if (fb_ready) begin
          if (r_fb_addr == LAST_ADDR) begin
            w_state_nxt = ST_IDLE;
            w_fb_we_nxt = 1'b0;
          end else begin
            w_fb_addr_nxt = r_fb_addr + FB_AW'(1);
          end
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_fb_we_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd     <= '0;
      r_cmd_vld <= 1'b0;
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_pop) r_cmd <= w_dout;
      r_cmd_vld <= w_cmd_vld_nxt;
      r_fb_we   <= w_fb_we_nxt;
      r_fb_addr <= w_fb_addr_nxt;
      r_fb_data <= w_fb_data_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE) || w_cmd_vld_nxt || (w_cnt_nxt != '0);
      r_ovf     <= r_ovf | (vga_wr & w_full & ~w_pop);
    end
  end

endmodule

// File: tb/tb_vga_cmd_bridge.sv
// Scoreboard bench for vga_cmd_bridge; expectations for CLEAR follow VGA_BRIDGE_CLEAR_EN.
module tb_vga_cmd_bridge;

  localparam int unsigned H     = 320;
  localparam int unsigned V     = 240;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_wr;
  logic [31:0] vga_word;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready;
  logic        busy;
  logic        ovf;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    rand_rdy = 1'b0;
  bit    rdy_force = 1'b1;

  vga_cmd_bridge #(.FIFO_DEPTH(DEPTH), .H_RES(H), .V_RES(V)) dut (
    .clk      (clk),
    .rst      (rst),
    .vga_wr   (vga_wr),
    .vga_word (vga_word),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_ready (fb_ready),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mk(logic [3:0] op, int x, int y, logic [7:0] col);
    return {op, 10'(x), 8'(y), 2'b00, col};
  endfunction

  // Reference: what the framebuffer should receive for one accepted command word.
  function automatic void model(logic [31:0] w);
    int    op, x, y;
    xfer_t t;
    op = int'(w[31:28]);
    x  = int'(w[27:18]);
    y  = int'(w[17:10]);
    t.data = w[7:0];
    if (op == 1 && x < int'(H) && y < int'(V)) begin
      t.addr = 17'(y * int'(H) + x);
      exp_q.push_back(t);
    end
`ifdef VGA_BRIDGE_CLEAR_EN
    else if (op == 2) begin
      for (int a = 0; a < int'(H * V); a++) begin
        t.addr = 17'(a);
        exp_q.push_back(t);
      end
    end
`endif
  endfunction

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [31:0] w, bit accepted);
    vga_word = w;
    vga_wr   = 1'b1;
    if (accepted) model(w);
    @(posedge clk);
    #1;
    vga_wr = 1'b0;
  endtask

  task automatic wait_idle(int budget, string name);
    int k = 0;
    while (busy && k < budget) begin
      cyc(1);
      k++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      6:       return mk(4'd0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), 8'($urandom));
      7:       return mk(4'($urandom_range(3, 15)), int'($urandom_range(0, 319)), int'($urandom_range(0, 239)), 8'($urandom));
      8:       return mk(4'd1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), 8'($urandom));
      default: return mk(4'd1, int'($urandom_range(0, 319)), int'($urandom_range(0, 239)), 8'($urandom));
    endcase
  endfunction

  initial begin
    int k;
    rst      = 1'b1;
    vga_wr   = 1'b0;
    vga_word = '0;
    fb_ready = 1'b1;

    fork
      // Monitor: every presented write must match the scoreboard head until accepted.
      forever begin
        @(negedge clk);
        if (!rst && fb_we) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: addr=%0d data=0x%0h expected no write", fb_addr, fb_data);
          end else begin
            check("xfer_addr", 32'(fb_addr), 32'(exp_q[0].addr));
            check("xfer_data", 32'(fb_data), 32'(exp_q[0].data));
            if (fb_ready) void'(exp_q.pop_front());
          end
        end
      end
      forever begin
        @(posedge clk);
        #2;
        fb_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
      end
      begin
        #990000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
      end
    join_none

    #1;
    check("rst_we",   32'(fb_we),   32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_data", 32'(fb_data), 32'd0);
    check("rst_busy", 32'(busy),    32'd0);
    check("rst_ovf",  32'(ovf),     32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Single pixel latency: fb_we rises after edge N+2 for one cycle.
    send(mk(4'd1, 10, 5, 8'h3C), 1'b1);
    check("lat_n_we", 32'(fb_we), 32'd0);
    cyc(1);
    check("lat_n1_we", 32'(fb_we), 32'd0);
    cyc(1);
    check("lat_n2_we",   32'(fb_we),   32'd1);
    check("lat_n2_addr", 32'(fb_addr), 32'd1610);
    check("lat_n2_data", 32'(fb_data), 32'h3C);
    cyc(1);
    check("lat_n3_we", 32'(fb_we), 32'd0);
    wait_idle(10, "pix");

    // Out-of-range pixel is discarded.
    send(mk(4'd1, 320, 0, 8'h55), 1'b1);
    check("oor_busy0", 32'(busy), 32'd1);
    cyc(1);
    check("oor_busy1", 32'(busy), 32'd1);
    cyc(1);
    check("oor_busy2", 32'(busy), 32'd0);
    check("oor_ovf",   32'(ovf),  32'd0);

    // Back-to-back pixels: one command per three cycles.
    send(mk(4'd1, 0, 0, 8'h01), 1'b1);
    send(mk(4'd1, 319, 239, 8'h02), 1'b1);
    cyc(1);
    check("tp_n2_we", 32'(fb_we), 32'd1);
    cyc(1);
    check("tp_n3_we", 32'(fb_we), 32'd0);
    cyc(1);
    check("tp_n4_we", 32'(fb_we), 32'd0);
    cyc(1);
    check("tp_n5_we", 32'(fb_we), 32'd1);
    wait_idle(10, "tp");

    // Stalled framebuffer: DEPTH queued plus one executing, then overflow.
    rdy_force = 1'b0;
    cyc(2);
    for (int i = 0; i < int'(DEPTH) + 1; i++)
      send(mk(4'd1, int'($urandom_range(0, 319)), int'($urandom_range(0, 239)), 8'($urandom)), 1'b1);
    check("stall_ovf0", 32'(ovf),   32'd0);
    check("stall_we",   32'(fb_we), 32'd1);
    send(mk(4'd1, 7, 7, 8'hEE), 1'b0);
    check("stall_ovf1", 32'(ovf), 32'd1);
    rdy_force = 1'b1;
    wait_idle(60, "ovf_drain");
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Randomized bursts that cannot overflow, with random fb_ready.
    rand_rdy = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int n;
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) begin
        send(rand_word(), 1'b1);
        cyc(int'($urandom_range(0, 2)));
      end
      wait_idle(300, "rand");
    end
    rand_rdy = 1'b0;
    cyc(1);
    check("rand_ovf_sticky", 32'(ovf), 32'd1);

    // Full-screen clear (no transfers when CLEAR is not built).
    send(mk(4'd2, 0, 0, 8'h07), 1'b1);
    wait_idle(80000, "clear");

    // Reset in the middle of an operation.
`ifdef VGA_BRIDGE_CLEAR_EN
    send(mk(4'd2, 0, 0, 8'h07), 1'b1);
    k = 0;
    while (fb_addr != 17'd100 && k < 500) begin
      cyc(1);
      k++;
    end
    check("clr_reach100", 32'(fb_addr), 32'd100);
`else
    rdy_force = 1'b0;
    cyc(2);
    send(mk(4'd1, 3, 4, 8'h11), 1'b1);
    cyc(2);
    check("abort_stall_we", 32'(fb_we), 32'd1);
`endif
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("abort_we",   32'(fb_we),   32'd0);
    check("abort_addr", 32'(fb_addr), 32'd0);
    check("abort_data", 32'(fb_data), 32'd0);
    check("abort_busy", 32'(busy),    32'd0);
    check("abort_ovf",  32'(ovf),     32'd0);
    @(posedge clk);
    #1;
    check("abort_hold_we", 32'(fb_we), 32'd0);
    rst       = 1'b0;
    rdy_force = 1'b1;
    cyc(2);

    send(mk(4'd1, 319, 239, 8'hA5), 1'b1);
    wait_idle(20, "post_rst");
    send(mk(4'd1, 0, 240, 8'h5A), 1'b1);
    wait_idle(20, "post_rst_oor");
    check("post_rst_ovf", 32'(ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_cmd_bridge.md
VGA_CMD_BRIDGE -- requirements
Module: vga_cmd_bridge

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter: H_RES, default 320, pixels per line.
REQ-003 Parameter: V_RES, default 240, lines per frame.
REQ-004 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: vga_wr  input  1  one-cycle strobe; register 15 is written this cycle (we3 & wa3==15).
REQ-007 Port: vga_word  input  32  command word written to register 15 (wd3).
REQ-008 Port: fb_we  output  1  framebuffer write request.
REQ-009 Port: fb_addr  output  17  linear pixel address, y*H_RES+x.
REQ-010 Port: fb_data  output  8  pixel colour.
REQ-011 Port: fb_ready  input  1  framebuffer accepts; transfer on a clock edge with fb_we & fb_ready.
REQ-012 Port: busy  output  1  high when FSM is not IDLE or FIFO is non-empty.
REQ-013 Port: ovf  output  1  sticky; a command was dropped because the FIFO was full.

Function
REQ-014 Word format SHALL be [31:28] opcode, [27:18] x, [17:10] y, [9:8] reserved (ignored), [7:0] colour.
REQ-015 Opcodes SHALL be 0 NOP, 1 PIXEL, 2 CLEAR; opcodes 3..15 SHALL be treated as NOP.
REQ-016 vga_wr with FIFO not full SHALL push vga_word; with FIFO full and no pop that cycle SHALL drop the word and set ovf.
REQ-017 Push and pop in the same cycle SHALL both take effect, including when full; a pop on empty SHALL be impossible.
REQ-018 FSM states SHALL be IDLE, PIXEL, CLEAR.
REQ-019 IDLE with FIFO non-empty SHALL pop the head and latch it in one cycle; PIXEL with x<H_RES and y<V_RES -> PIXEL; CLEAR -> CLEAR with fb_addr=0, fb_data=colour; NOP or out-of-range PIXEL -> stay IDLE, word discarded.
REQ-020 PIXEL SHALL hold fb_we=1 with stable fb_addr/fb_data until fb_ready, then return to IDLE.
REQ-021 CLEAR SHALL hold fb_we=1, increment fb_addr on each accepted transfer, and return to IDLE after address H_RES*V_RES-1 is accepted.
REQ-022 fb_we, fb_addr and fb_data SHALL be registered; fb_addr/fb_data SHALL change only on accepted transfers or on entry to PIXEL/CLEAR.
REQ-023 Latency: with FSM IDLE and FIFO empty, vga_wr sampled at edge N SHALL give fb_we=1 after edge N+2; single PIXEL throughput is one command per 3 cycles with fb_ready tied high.
REQ-024 vga_wr arriving during PIXEL/CLEAR SHALL be queued, never lost unless the FIFO is full.
REQ-025 fb_addr arithmetic SHALL be 17-bit unsigned; no wrap beyond H_RES*V_RES-1.

Reset
REQ-026 rst SHALL immediately (asynchronously) clear FSM to IDLE, empty the FIFO, and drive fb_we=0, fb_addr=0, fb_data=0, busy=0, ovf=0.
REQ-027 rst asserted mid-PIXEL or mid-CLEAR SHALL abort the operation; no transfer SHALL complete on the edge where rst is high.
REQ-028 ovf SHALL be cleared only by rst.

Configuration
REQ-029 Macro VGA_BRIDGE_CLEAR_EN defined: CLEAR state and opcode 2 SHALL be implemented as in REQ-019/021.
REQ-030 Macro VGA_BRIDGE_CLEAR_EN undefined: CLEAR state SHALL not exist and opcode 2 SHALL be treated as NOP.

Structure
REQ-031 Package vga_bridge_pkg SHALL hold the opcode enum, FSM state enum, word field bit positions and FB_AW=17.
REQ-032 FIFO SHALL be a separate sub-module vga_cmd_fifo (parameter DEPTH, width 32, full/empty, push/pop).

Verification
REQ-033 vga_wr with 0x1_0A_05_00_3C pattern (x=10, y=5, colour 0x3C), fb_ready=1 -> one transfer fb_addr=1610, fb_data=0x3C, fb_we high after edge N+2 for one cycle.
REQ-034 PIXEL x=320,y=0 -> no fb_we, busy falls after 2 cycles, ovf=0.
REQ-035 Five back-to-back PIXEL strobes with fb_ready=0, FIFO_DEPTH=4 -> 4 queued plus 1 in PIXEL, no ovf; sixth strobe -> ovf=1; release fb_ready -> five transfers in order.
REQ-036 CLEAR colour 0x07 with fb_ready=1 -> 76800 transfers, addresses 0..76799, all data 0x07, then IDLE; macro undefined -> zero transfers.
REQ-037 rst pulsed mid-CLEAR at address 100 -> fb_we=0 immediately, FIFO empty, ovf=0; next PIXEL command executes normally.
REQ-038 fb_ready toggling randomly during PIXEL -> fb_addr/fb_data stable until the accepting edge.
